// File: rtl/r_empty_fwft.sv
// Read-side control for the dual-clock FIFO: write-pointer synchroniser, read pointer,
// empty/almost_empty flags and a 2-entry first-word-fall-through output stage.
module r_empty_fwft #(
  parameter int unsigned ADDR_SIZE  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_SIZE:0]    w_ptr_async,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_SIZE-1:0]  mem_raddr,
  output logic                  mem_ren,
  output logic [ADDR_SIZE:0]    r_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    r_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0]         s1;
  logic [PW-1:0]         w_ptr_sync;
  logic [PW-1:0]         w_bin_sync;
  logic [PW-1:0]         r_bin;
  logic [PW-1:0]         r_bin_next;
  logic [PW-1:0]         r_gray_next;
  logic [PW-1:0]         r_count_next;
  logic                  inflight;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop;
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  head_valid_n;
  logic                  skid_valid_n;
  logic [DATA_WIDTH-1:0] head_data_n;
  logic [DATA_WIDTH-1:0] skid_data_n;

  // Two-flop synchroniser for the write Gray pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= '0;
      w_ptr_sync <= '0;
    end else begin
      s1         <= w_ptr_async;
      w_ptr_sync <= s1;
    end
  end

  assign w_bin_sync = gray2bin(w_ptr_sync);

  // Fetch only while the stage plus the word in flight leaves a free slot after this pop
  assign pop     = dout_valid & dout_ready;
  assign occ     = 2'(dout_valid) + 2'(skid_valid);
  assign level   = 3'(occ) + 3'(inflight) - 3'(pop);
  assign mem_ren = ~empty & (level < 3'd2);

  assign r_bin_next   = r_bin + PW'(mem_ren);
  assign r_gray_next  = r_bin_next ^ (r_bin_next >> 1);
  assign r_count_next = w_bin_sync - r_bin_next;
  assign mem_raddr    = r_bin[ADDR_SIZE-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin        <= '0;
      r_ptr        <= '0;
      r_count      <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      inflight     <= 1'b0;
    end else begin
      r_bin        <= r_bin_next;
      r_ptr        <= r_gray_next;
      r_count      <= r_count_next;
      empty        <= (r_gray_next == w_ptr_sync);
      almost_empty <= (r_count_next <= PW'(AE_THRESH));
      inflight     <= mem_ren;
    end
  end

  // Output stage: skid drains into head first so word order is preserved
  always_comb begin
    head_valid_n = dout_valid;
    head_data_n  = dout;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (pop) begin
      if (skid_valid) begin
        head_data_n  = skid_data;
        skid_valid_n = inflight;
        if (inflight) skid_data_n = mem_rdata;
      end else begin
        head_valid_n = inflight;
        if (inflight) head_data_n = mem_rdata;
      end
    end else if (inflight) begin
      if (dout_valid) begin
        skid_valid_n = 1'b1;
        skid_data_n  = mem_rdata;
      end else begin
        head_valid_n = 1'b1;
        head_data_n  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      dout_valid <= head_valid_n;
      dout       <= head_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
    end
  end

endmodule

// File: tb/tb_r_empty_fwft.sv
// Randomized bench for r_empty_fwft: bench-side memory/writer plus a queue-based
// reference of synchronisation delay, fetch rule and FWFT ordering.
module tb_r_empty_fwft;

  localparam int AS    = 3;
  localparam int DW    = 8;
  localparam int PW    = AS + 1;
  localparam int DEPTH = 1 << AS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] w_ptr_async = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic [AS-1:0] mem_raddr;
  logic          mem_ren;
  logic [PW-1:0] r_ptr;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] r_count;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  r_empty_fwft #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .w_ptr_async(w_ptr_async), .mem_rdata(mem_rdata),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .r_ptr(r_ptr), .empty(empty),
    .almost_empty(almost_empty), .r_count(r_count), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  // FIFO memory with registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  int checks = 0;
  int errors = 0;

  // Reference state: counts of words written, synchronised, fetched, popped
  int            wb, popped, fetched, s1b, s2b;
  bit            e_empty, infl_m;
  int            e_count;
  logic [DW-1:0] pend;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] outq[$];

  function automatic int m16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(m16(b));
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_pop();
    return (outq.size() > 0) && dout_ready;
  endfunction

  function automatic bit exp_ren();
    return !e_empty && ((outq.size() + int'(infl_m) - int'(exp_pop())) < 2);
  endfunction

  task automatic model_reset();
    wb = 0; popped = 0; fetched = 0; s1b = 0; s2b = 0;
    e_empty = 1'b1; e_count = 0; infl_m = 1'b0; pend = '0;
    wq.delete(); outq.delete();
    w_ptr_async = '0;
  endtask

  task automatic check_outputs();
    check("mem_ren", 32'(mem_ren), 32'(exp_ren()));
    check("empty", 32'(empty), 32'(e_empty));
    check("r_count", 32'(r_count), 32'(e_count));
    check("almost_empty", 32'(almost_empty), 32'(e_count <= 2));
    check("r_ptr", 32'(r_ptr), 32'(to_gray(fetched)));
    check("mem_raddr", 32'(mem_raddr), 32'(fetched % DEPTH));
    check("dout_valid", 32'(dout_valid), 32'(outq.size() > 0));
    if (outq.size() > 0) check("dout", 32'(dout), 32'(outq[0]));
  endtask

  task automatic model_edge();
    bit pop, ren;
    int fn;
    pop = exp_pop();
    ren = exp_ren();
    fn  = fetched + int'(ren);
    e_empty = (m16(s2b) == m16(fn));
    e_count = m16(s2b - fn);
    if (pop) begin
      void'(outq.pop_front());
      popped++;
    end
    if (infl_m) outq.push_back(pend);
    if (ren) begin
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL fetch_underrun fetched=%0d written=%0d", fetched, wb);
      end else pend = wq.pop_front();
    end
    infl_m  = ren;
    fetched = fn;
    s2b = s1b;
    s1b = wb;
  endtask

  // One cycle: drive at negedge, check, then advance the model at posedge
  task automatic step(input int p_wr, input int p_rd);
    int k;
    dout_ready = ($urandom_range(99) < p_rd);
    if ($urandom_range(99) < p_wr) begin
      k = ($urandom_range(9) == 0) ? 2 : 1;
      for (int i = 0; i < k; i++) begin
        if (wb - popped < DEPTH) begin
          mem[wb % DEPTH] = DW'($urandom);
          wq.push_back(mem[wb % DEPTH]);
          wb++;
        end
      end
    end
    w_ptr_async = to_gray(wb);
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_r_ptr", 32'(r_ptr), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_r_count", 32'(r_count), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic phase(input int p_wr, input int p_rd, input int n);
    for (int i = 0; i < n; i++) step(p_wr, p_rd);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge clk);
    do_reset();
    phase(0, 100, 4);
    // single word held under back-pressure, then popped
    phase(100, 0, 1);
    phase(0, 0, 8);
    phase(0, 100, 4);
    // fill the memory, then stream it out
    phase(100, 0, 12);
    phase(0, 100, 14);
    phase(100, 100, 40);
    phase(100, 0, 20);
    phase(0, 100, 16);
    phase(50, 50, 300);
    phase(20, 90, 100);
    phase(90, 20, 100);
    // reset while the output stage is loaded
    phase(100, 0, 5);
    do_reset();
    phase(0, 100, 6);
    phase(60, 60, 200);
    phase(0, 100, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
